// File: rtl/sync_fifo_pkg.sv
// Shared constants, helpers and types for the parametrised synchronous FIFO family.
package sync_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 8;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'b00,
    FIFO_OP_PUSH = 2'b01,
    FIFO_OP_POP  = 2'b10,
    FIFO_OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_fifo_gen_if.sv
// Producer/consumer bundle for sync_fifo_gen; master drives requests, slave is the FIFO.
interface sync_fifo_gen_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
);

  localparam int CW = clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage with one synchronous write port and one read port.
// SYNC_FIFO_FWFT_EN selects a combinational (fall-through) read port instead of a registered one.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_fwft;

  assign rd_data     = mem[rd_addr];
  assign unused_fwft = rst ^ rd_en;
`else
  // rd_en here is the already-qualified pop, so dout holds whenever nothing is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO: pointers, occupancy count, flag decode and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_gen
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_gen_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          empty_w;
  logic          full_w;
  logic          wr_ok;
  logic          rd_ok;
  fifo_op_e      op;

  // Flags come only from the registered count, so they cannot glitch on request inputs.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  assign wr_ok = bus.wr_en && !full_w;
  assign rd_ok = bus.rd_en && !empty_w;

  always_comb begin
    op = FIFO_OP_IDLE;
    if (wr_ok && rd_ok) begin
      op = FIFO_OP_BOTH;
    end else if (wr_ok) begin
      op = FIFO_OP_PUSH;
    end else if (rd_ok) begin
      op = FIFO_OP_POP;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case (op)
        FIFO_OP_PUSH: count_q <= count_q + CW'(1);
        FIFO_OP_POP:  count_q <= count_q - CW'(1);
        default:      count_q <= count_q;
      endcase
      overflow_q  <= bus.wr_en && full_w;
      underflow_q <= bus.rd_en && empty_w;
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (bus.din),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (bus.dout)
  );

  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Self-checking bench for sync_fifo_gen: directed scenarios plus random traffic against a queue model.
// Honours SYNC_FIFO_FWFT_EN the same way the design does.
module tb_sync_fifo_gen;
  import sync_fifo_pkg::*;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;
  localparam int AE_LEVEL = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sync_fifo_gen_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_gen #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total = 0;
  int         bad   = 0;
  int         cycle = 0;
  logic [7:0] model_q [$];
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ovf  = 1'b0;
  logic       exp_udf  = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  // One clock of stimulus: drive, let the edge happen, advance the model, then compare.
  task automatic apply_stimulus(input logic r, input logic w, input logic [7:0] d, input logic rd);
    int         sz;
    logic [7:0] popped;
    rst       = r;
    bus.wr_en = w;
    bus.din   = d;
    bus.rd_en = rd;
    @(posedge clk);
    cycle++;
    sz = model_q.size();
    if (r) begin
      model_q.delete();
      exp_dout = 8'h00;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
    end else begin
      exp_ovf = w && (sz == DEPTH);
      exp_udf = rd && (sz == 0);
      if (rd && sz > 0) begin
        popped = model_q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
        exp_dout = popped;
`endif
      end
      if (w && sz < DEPTH) begin
        model_q.push_back(d);
      end
    end
    #1;
    sz = model_q.size();
    check_output("count",        32'(bus.count),        32'(sz));
    check_output("empty",        32'(bus.empty),        32'(sz == 0));
    check_output("full",         32'(bus.full),         32'(sz == DEPTH));
    check_output("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE_LEVEL));
    check_output("almost_full",  32'(bus.almost_full),  32'(sz >= AF_LEVEL));
    check_output("overflow",     32'(bus.overflow),     32'(exp_ovf));
    check_output("underflow",    32'(bus.underflow),    32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
    if (sz > 0) begin
      check_output("dout_fwft", 32'(bus.dout), 32'(model_q[0]));
    end
`else
    check_output("dout", 32'(bus.dout), 32'(exp_dout));
`endif
  endtask

  initial begin
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.din   = '0;
    bus.rd_en = 1'b0;

    // Reset, then idle
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Fill 0x01..0x08, then a rejected ninth write
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(i), 1'b0);
    end
    apply_stimulus(1'b0, 1'b1, 8'hAA, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Drain in order, then read while empty
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    end
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Simultaneous write/read while full, then while empty
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'($urandom), 1'b0);
    end
    apply_stimulus(1'b0, 1'b1, 8'hE7, 1'b1);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    end
    apply_stimulus(1'b0, 1'b1, 8'h3C, 1'b1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);

    // Pointer wrap at steady occupancy of four
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'($urandom), 1'b1);
    end

    // Mid-stream reset, then a fresh start
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    end
    apply_stimulus(1'b1, 1'b1, 8'hFF, 1'b1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h5C, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h5D, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    end

    // Random traffic in phases biased toward filling, draining and balance
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 150; i++) begin
        int  wr_pct;
        int  rd_pct;
        wr_pct = (phase == 0) ? 75 : (phase == 1) ? 25 : 50;
        rd_pct = 100 - wr_pct;
        apply_stimulus($urandom_range(0, 99) < 2,
                       $urandom_range(0, 99) < wr_pct,
                       8'($urandom),
                       $urandom_range(0, 99) < rd_pct);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
